mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS-subset datapath. Per instruction it sequences
//  fetch, decode, execute, memory and write-back over several clocks, sharing one ALU and one memory port.
//  Waits on memory via a ready handshake and traps on illegal opcodes or memory timeout.
//  Sits between the IR/ALU-zero feedback and the datapath mux/write-enable controls.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive mem_ready=0 cycles in one memory state before trap; 0 = never time out
// PORTS
//  clk          in   1   clock, all state changes on rising edge
//  reset        in   1   synchronous, active-high
//  instruction  in   32  IR contents; opcode = [31:26]
//  zero         in   1   ALU zero flag
//  mem_ready    in   1   memory completes the current access this cycle
//  pc_write     out  1   PC load enable
//  ir_write     out  1   IR load enable
//  mem_read     out  1   memory read request; also sets address source: PC in FETCH, ALUOut in MEM_RD
//  mem_write    out  1   memory write request
//  reg_dst      out  1   1 = rd, 0 = rt
//  mem_to_reg   out  1   1 = MDR, 0 = ALUOut
//  reg_write    out  1   register file write enable
//  alu_src_a    out  1   0 = PC, 1 = reg A
//  alu_src_b    out  2   00 B, 01 const 4, 10 ext imm, 11 sext imm<<2
//  ext_zero     out  1   1 = zero-extend imm (andi/ori), 0 = sign-extend
//  alu_op       out  3   000 add, 001 sub, 010 funct decode, 011 and, 100 or
//  pc_src       out  2   00 ALU result, 01 ALUOut, 10 {PC[31:28],instr[25:0],2'b00}
//  retire       out  1   one-cycle pulse in final cycle of each instruction
//  trap         out  1   sticky error flag; cleared only by reset
// BEHAVIOUR
//  Opcodes: R 000000, lw 100011, sw 101011, addi 001000, andi 001100, ori 001101, beq 000100, j 000010.
//  Sync reset: state = RST, timeout counter = 0, trap = 0. All outputs are 0 in RST. The next clock always enters FETCH.
//  Outputs are decoded from the state register. Only the enables named below also depend on mem_ready or zero.
//  Unlisted outputs are 0 in every state.
//  FETCH: mem_read=1, alu_src_b=01, alu_op=add, pc_src=00. pc_write=ir_write=mem_ready.
//    Go to DECODE when mem_ready=1; otherwise stay.
//  DECODE: alu_src_b=11, alu_op=add (branch target into ALUOut). Next state by opcode:
//    lw/sw -> MEM_ADDR; R -> EXEC_R; addi/andi/ori -> EXEC_I; beq -> BRANCH; j -> JUMP; other -> TRAP.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add. Next: MEM_RD for lw, MEM_WR for sw.
//  MEM_RD: mem_read=1. Go to MEM_WB when mem_ready=1.
//  MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1. Next: FETCH.
//  MEM_WR: mem_write=1. retire=mem_ready. Go to FETCH when mem_ready=1.
//  EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010. Next: R_WB.
//  R_WB: reg_write=1, reg_dst=1, retire=1. Next: FETCH.
//  EXEC_I: alu_src_a=1, alu_src_b=10. addi: alu_op=add. andi: alu_op=and, ext_zero=1.
//    ori: alu_op=or, ext_zero=1. Next: I_WB.
//  I_WB: reg_write=1, reg_dst=0, retire=1. Hold the EXEC_I ALU controls. Next: FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01, pc_write=zero, retire=1. Next: FETCH.
//  JUMP: pc_src=10, pc_write=1, retire=1. Next: FETCH.
//  TRAP: trap=1, all other outputs 0. The state is held until reset.
//  Cycles at zero wait: beq/j 3; R/addi/andi/ori/sw 4; lw 5. Each mem_ready=0 cycle adds 1.
//  Timeout: the counter clears on entry to FETCH, MEM_RD and MEM_WR, and on any cycle with mem_ready=1.
//    It increments on each mem_ready=0 cycle in those states. Reaching MEM_TIMEOUT sends the FSM to TRAP
//    on the next clock, with no enables asserted in that cycle.
//  reset has priority over every event. Reset mid-access drops mem_read/mem_write in the following cycle,
//    discarding the access. mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
// TESTING
//  1. reset high 2 clocks, then low, mem_ready=1, R-type in IR -> all outputs 0 while in RST.
//     Then FETCH/DECODE/EXEC_R/R_WB; reg_dst=1 and reg_write=1 in cycle 4; retire exactly once.
//  2. lw (0x8C...) with mem_ready low 2 cycles in MEM_RD -> 7 cycles total; mem_read held 3 cycles;
//     reg_write and mem_to_reg=1 only in MEM_WB.
//  3. beq with zero=1, then beq with zero=0 -> pc_write=1, pc_src=01 in BRANCH for the first; pc_write=0 for the second.
//  4. ori (0x34...) -> ext_zero=1, alu_op=100 in EXEC_I and I_WB. j (0x08...) -> pc_src=10, pc_write=1 in cycle 3.
//  5. opcode 0x3F -> TRAP after DECODE, trap=1 sticky, no further pc_write. Reset returns the FSM to RST, then FETCH.
//  6. MEM_TIMEOUT=3, mem_ready stuck 0 in FETCH -> TRAP after 3 wait cycles.
//     Then reset asserted mid-MEM_WR -> mem_write=0 the next cycle.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/write-back over a shared ALU and
// memory port, stalls on mem_ready, and traps on illegal opcodes or on a
// memory access that stays unready for MEM_TIMEOUT consecutive cycles.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_zero,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        retire,
  output logic        trap
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  // Counter only needs to reach MEM_TIMEOUT; keep at least one bit.
  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, TRAP
  } state_t;

  state_t        state, nextState;
  logic [CW-1:0] waitCnt, waitCntNext;
  logic [5:0]    opcode;
  logic          memState, timedOut;
  logic          unusedIr;

  assign opcode   = instruction[31:26];
  assign unusedIr = ^instruction[25:0];

  // Only the three memory-access states can stall on mem_ready.
  assign memState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timedOut = (MEM_TIMEOUT != 0) && memState && (waitCnt == CW'(MEM_TIMEOUT));

  // Stall counter: counts consecutive unready cycles, zero everywhere else,
  // which also gives the clear-on-entry behaviour for the memory states.
  assign waitCntNext = (MEM_TIMEOUT != 0 && memState && !mem_ready && !timedOut)
                       ? waitCnt + CW'(1) : '0;

  // State and stall-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RST;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
    end
  end

  // Next-state and datapath controls decoded from the current state.
  always_comb begin
    nextState  = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    alu_op     = ALU_ADD;
    pc_src     = 2'b00;
    retire     = 1'b0;
    trap       = 1'b0;
    case (state)
      RST: nextState = FETCH;
      FETCH: begin
        alu_src_b = 2'b01;
        if (timedOut) nextState = TRAP;
        else begin
          mem_read = 1'b1;
          pc_write = mem_ready;
          ir_write = mem_ready;
          if (mem_ready) nextState = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:             nextState = MEM_ADDR;
          OP_R:                     nextState = EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: nextState = EXEC_I;
          OP_BEQ:                   nextState = BRANCH;
          OP_J:                     nextState = JUMP;
          default:                  nextState = TRAP;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nextState = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        if (timedOut) nextState = TRAP;
        else begin
          mem_read = 1'b1;
          if (mem_ready) nextState = MEM_WB;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        nextState  = FETCH;
      end
      MEM_WR: begin
        if (timedOut) nextState = TRAP;
        else begin
          mem_write = 1'b1;
          retire    = mem_ready;
          if (mem_ready) nextState = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        nextState = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        nextState = FETCH;
      end
      EXEC_I, I_WB: begin
        // I_WB keeps the EXEC_I ALU setup so ALU result stays stable for write-back.
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ANDI) begin
          alu_op   = ALU_AND;
          ext_zero = 1'b1;
        end else if (opcode == OP_ORI) begin
          alu_op   = ALU_OR;
          ext_zero = 1'b1;
        end
        if (state == I_WB) begin
          reg_write = 1'b1;
          retire    = 1'b1;
          nextState = FETCH;
        end else begin
          nextState = I_WB;
        end
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_write  = zero;
        retire    = 1'b1;
        nextState = FETCH;
      end
      JUMP: begin
        pc_src    = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
        nextState = FETCH;
      end
      TRAP: trap = 1'b1;
      default: nextState = RST;
    endcase
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: each instruction is modelled as a list of
// phases with expected control words; random mem_ready stalls stretch the
// memory phases and the cycle count is checked against the opcode latency.
module tb_mips_multicycle_ctrl;
  localparam int TMO = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero, mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write, reg_dst, mem_to_reg;
  logic        reg_write, alu_src_a, ext_zero, retire, trap;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_op;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_op(alu_op),
    .pc_src(pc_src), .retire(retire), .trap(trap)
  );

  always #5 clk = ~clk;

  // Control word layout, MSB first, matching the port list.
  logic [17:0] obs;
  assign obs = {pc_write, ir_write, mem_read, mem_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, ext_zero, alu_op, pc_src,
                retire, trap};

  localparam logic [17:0] PCW = 18'h20000, IRW = 18'h10000, MR  = 18'h08000;
  localparam logic [17:0] MW  = 18'h04000, RDST = 18'h02000, M2R = 18'h01000;
  localparam logic [17:0] RW  = 18'h00800, ASA = 18'h00400, EZ  = 18'h00080;
  localparam logic [17:0] RET = 18'h00002, TRP = 18'h00001;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_BEQ = 6'h04, OP_J = 6'h02;

  function automatic logic [17:0] fAsb(logic [1:0] v); return {8'b0, v, 8'b0}; endfunction
  function automatic logic [17:0] fOp(logic [2:0] v);  return {11'b0, v, 4'b0}; endfunction
  function automatic logic [17:0] fPc(logic [1:0] v);  return {14'b0, v, 2'b0}; endfunction

  typedef struct {
    logic [17:0] base;  // outputs independent of mem_ready
    logic [17:0] rdy;   // outputs that follow mem_ready
    bit          wt;    // phase repeats until mem_ready=1
  } step_t;

  step_t stq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void addStep(logic [17:0] b, logic [17:0] r, bit w);
    step_t s;
    s.base = b; s.rdy = r; s.wt = w;
    stq.push_back(s);
  endfunction

  function automatic bit legal(logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_J};
  endfunction

  function automatic int baseCycles(logic [5:0] op);
    if (op == OP_BEQ || op == OP_J) return 3;
    if (op == OP_LW) return 5;
    return 4;
  endfunction

  // Phase list of one instruction; illegal opcodes stop after decode.
  function automatic void buildSteps(logic [5:0] op, logic z);
    logic [17:0] aluI;
    stq.delete();
    addStep(MR | fAsb(2'b01), PCW | IRW, 1'b1);
    addStep(fAsb(2'b11), '0, 1'b0);
    aluI = ASA | fAsb(2'b10);
    if (op == OP_ANDI) aluI = aluI | EZ | fOp(3'b011);
    if (op == OP_ORI)  aluI = aluI | EZ | fOp(3'b100);
    case (op)
      OP_LW: begin
        addStep(ASA | fAsb(2'b10), '0, 1'b0);
        addStep(MR, '0, 1'b1);
        addStep(RW | M2R | RET, '0, 1'b0);
      end
      OP_SW: begin
        addStep(ASA | fAsb(2'b10), '0, 1'b0);
        addStep(MW, RET, 1'b1);
      end
      OP_R: begin
        addStep(ASA | fOp(3'b010), '0, 1'b0);
        addStep(RDST | RW | RET, '0, 1'b0);
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        addStep(aluI, '0, 1'b0);
        addStep(aluI | RW | RET, '0, 1'b0);
      end
      OP_BEQ: addStep(ASA | fOp(3'b001) | fPc(2'b01) | RET | (z ? PCW : 18'h0), '0, 1'b0);
      OP_J:   addStep(fPc(2'b10) | PCW | RET, '0, 1'b0);
      default: ;
    endcase
  endfunction

  // Entered just after a rising edge with the FSM in FETCH.
  // fixedWaits<0: random stalls (at most 2 in a row); else fetch has none
  // and each later memory phase stalls exactly fixedWaits cycles.
  task automatic runInstr(input string tag, input logic [31:0] ins, input logic z, input int fixedWaits);
    int cyc, waits, rets, zeros, target;
    bit done;
    logic [17:0] exp;
    cyc = 0; waits = 0; rets = 0;
    buildSteps(ins[31:26], z);
    instruction = ins;
    zero = z;
    for (int s = 0; s < stq.size(); s++) begin
      zeros = 0;
      done = 1'b0;
      while (!done) begin
        if (stq[s].wt) begin
          if (fixedWaits >= 0) begin
            target = (s == 0) ? 0 : fixedWaits;
            mem_ready = (zeros >= target);
          end else begin
            mem_ready = (zeros >= 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
          end
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        #1;
        exp = stq[s].base | (mem_ready ? stq[s].rdy : 18'h0);
        chk($sformatf("%s_ph%0d", tag, s), 32'(obs), 32'(exp));
        if (retire) rets++;
        @(posedge clk); #1;
        cyc++;
        if (stq[s].wt && !mem_ready) begin zeros++; waits++; end
        else done = 1'b1;
      end
    end
    if (legal(ins[31:26])) begin
      chk({tag, "_cycles"}, 32'(cyc), 32'(baseCycles(ins[31:26]) + waits));
      chk({tag, "_retires"}, 32'(rets), 32'd1);
    end
  endtask

  // Reset for two clocks, then leave the FSM in FETCH just after an edge.
  task automatic doReset(input string tag);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk({tag, "_rst"}, 32'(obs), 32'h0);
    end
    reset = 1'b0;
    #1;
    chk({tag, "_rst_idle"}, 32'(obs), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [5:0]  ops [8];
    logic [31:0] r;
    ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_J};
    reset = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b0;
    instruction = 32'h012A4020;

    doReset("init");
    runInstr("add", 32'h012A4020, 1'b0, 0);
    runInstr("lw_wait2", 32'h8C880004, 1'b0, 2);
    runInstr("beq_taken", 32'h1109FFFC, 1'b1, 0);
    runInstr("beq_not", 32'h1109FFFC, 1'b0, 0);
    runInstr("ori", 32'h34A5F00F, 1'b0, 0);
    runInstr("j", 32'h08000010, 1'b0, 0);
    runInstr("sw_wait1", 32'hAC880008, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      runInstr($sformatf("rnd%0d", i), {ops[$urandom_range(0, 7)], r[25:0]},
               1'($urandom_range(0, 1)), -1);
    end

    // Illegal opcode: trap holds, no enables, mem_ready ignored.
    runInstr("illegal", 32'hFC000000, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("trap_hold%0d", i), 32'(obs), 32'(TRP));
      @(posedge clk); #1;
    end
    doReset("trap");
    runInstr("addi_after_trap", 32'h2108FFFF, 1'b0, 0);

    // Fetch that never completes: TMO stall cycles, one idle cycle, then trap.
    mem_ready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      #1;
      chk($sformatf("tmo_wait%0d", i), 32'(obs), 32'(MR | fAsb(2'b01)));
      @(posedge clk); #1;
    end
    #1;
    chk("tmo_idle", 32'(obs), 32'(fAsb(2'b01)));
    @(posedge clk); #1;
    chk("tmo_trap", 32'(obs), 32'(TRP));
    @(posedge clk); #1;
    chk("tmo_trap_hold", 32'(obs), 32'(TRP));

    // Reset in the middle of a store drops mem_write on the next cycle.
    doReset("tmo");
    instruction = 32'hAC880008;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    #1;
    chk("sw_pending", 32'(obs), 32'(MW));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("sw_reset_drop", 32'(obs), 32'h0);
    reset = 1'b0;
    #1;
    chk("sw_reset_idle", 32'(obs), 32'h0);
    @(posedge clk); #1;
    runInstr("r_after_reset", 32'h012A4022, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
